custom_reg_bridge: RTL and testbench

//  Upstream register front-end for the custom IP. Decodes a simple req/gnt register bus

---
 rtl/custom_reg_bridge.sv | 177 +++++++++++++++++
 tb/tb_custom_reg_bridge.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/custom_reg_bridge.sv
// rtl/custom_reg_bridge.sv - req/gnt register bus to per-channel reg2ip strobes with ack/timeout,
// ip2reg shadow capture, sticky status and interrupt.
module custom_reg_bridge #(
    parameter int NUM_CH      = 3,
    parameter int DW          = 32,
    parameter int AW          = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        addr_i,
    input  logic [31:0]          wdata_i,
    input  logic [3:0]           be_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic                 err_o,
    output logic [NUM_CH*DW-1:0] reg2ip_data_o,
    output logic [NUM_CH-1:0]    reg2ip_en_o,
    input  logic [NUM_CH-1:0]    reg2ip_ack_i,
    input  logic [NUM_CH*DW-1:0] ip2reg_data_i,
    input  logic [NUM_CH-1:0]    ip2reg_valid_i,
    output logic                 irq_o
);
    localparam int CW = $clog2(ACK_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = CW'(ACK_TIMEOUT - 1);

    typedef enum logic {IDLE, PEND} ch_state_e;

    ch_state_e                 state_q [NUM_CH];
    ch_state_e                 state_d [NUM_CH];
    logic [CW-1:0]             cnt_q [NUM_CH];
    logic [CW-1:0]             cnt_d [NUM_CH];
    logic [NUM_CH-1:0][DW-1:0] staging_q, staging_d, shadow_q, shadow_d;
    logic [NUM_CH-1:0]         valid_q, valid_d, tmo_q, tmo_d;
    logic                      rvalid_q, rvalid_d, err_q, err_d, irq_q, irq_d;
    logic [31:0]               rdata_q, rdata_d, status;
    logic [AW-3:0]             word;
    logic [NUM_CH-1:0]         sel_wdata, sel_rdata, pend;
    logic [NUM_CH-1:0]         rd_clr, w1c_valid, w1c_tmo, tmo_set;
    logic                      sel_status, sel_clear, stall, accept, dec_err;
    logic                      unused_addr;

    assign word        = addr_i[AW-1:2];
    assign unused_addr = ^addr_i[1:0];

    always_comb begin
        sel_wdata = '0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i < 4) begin
                sel_wdata[i] = (word == (AW-2)'(i));
                sel_rdata[i] = (word == (AW-2)'(4 + i));
            end
        end
        sel_status = (word == (AW-2)'(8));
        sel_clear  = (word == (AW-2)'(9));
    end

    always_comb begin
        status = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pend[i]        = (state_q[i] == PEND);
            status[i]      = pend[i];
            status[8 + i]  = valid_q[i];
            status[16 + i] = tmo_q[i];
        end
    end

    // A new WDATA write must not overwrite staging while the IP may still be sampling it.
    assign stall   = req_i & we_i & |(sel_wdata & pend);
    assign gnt_o   = req_i & ~stall;
    assign accept  = gnt_o;
    assign dec_err = we_i ? ~(|sel_wdata | sel_clear)
                          : ~(|sel_wdata | |sel_rdata | sel_status);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        staging_d = staging_q;
        shadow_d  = shadow_q;
        rvalid_d  = accept;
        err_d     = accept & dec_err;
        rdata_d   = '0;
        irq_d     = |tmo_q;
        rd_clr    = '0;
        w1c_valid = '0;
        w1c_tmo   = '0;
        tmo_set   = '0;
        valid_d   = valid_q;
        tmo_d     = tmo_q;

        if (accept && !we_i && !dec_err) begin
            if (sel_status) rdata_d = status;
            for (int i = 0; i < NUM_CH; i++) begin
                if (sel_wdata[i]) rdata_d = staging_q[i];
                if (sel_rdata[i]) begin
                    rdata_d   = shadow_q[i];
                    rd_clr[i] = 1'b1;
                end
            end
        end

        for (int i = 0; i < NUM_CH; i++) begin
            if (accept && we_i && sel_clear) begin
                w1c_valid[i] = wdata_i[8 + i];
                w1c_tmo[i]   = wdata_i[16 + i];
            end
            case (state_q[i])
                IDLE: begin
                    if (accept && we_i && sel_wdata[i]) begin
                        state_d[i] = PEND;
                        cnt_d[i]   = '0;
                        for (int b = 0; b < 4; b++) begin
                            if (be_i[b]) staging_d[i][8*b +: 8] = wdata_i[8*b +: 8];
                        end
                    end
                end
                PEND: begin
                    if (reg2ip_ack_i[i]) begin
                        state_d[i] = IDLE;
                    end else if (cnt_q[i] == CNT_MAX) begin
                        state_d[i] = IDLE;
                        tmo_set[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
            if (ip2reg_valid_i[i]) shadow_d[i] = ip2reg_data_i[i*DW +: DW];
            // Setting a sticky takes priority over any clear in the same cycle.
            valid_d[i] = ip2reg_valid_i[i] | (valid_q[i] & ~rd_clr[i] & ~w1c_valid[i]);
            tmo_d[i]   = tmo_set[i] | (tmo_q[i] & ~w1c_tmo[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            staging_q <= '0;
            shadow_q  <= '0;
            valid_q   <= '0;
            tmo_q     <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            staging_q <= staging_d;
            shadow_q  <= shadow_d;
            valid_q   <= valid_d;
            tmo_q     <= tmo_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    assign rvalid_o      = rvalid_q;
    assign rdata_o       = rdata_q;
    assign err_o         = err_q;
    assign irq_o         = irq_q;
    assign reg2ip_en_o   = pend;
    assign reg2ip_data_o = staging_q;

endmodule

// File: tb/tb_custom_reg_bridge.sv
// tb/tb_custom_reg_bridge.sv - randomized bus/IP stimulus checked against a register-map model.
module tb_custom_reg_bridge;
    localparam int NUM_CH = 3;
    localparam int DW     = 32;
    localparam int AW     = 8;
    localparam int TMO    = 16;
    localparam int CYCLES = 4000;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 req_i = 1'b0, we_i = 1'b0;
    logic [AW-1:0]        addr_i = '0;
    logic [31:0]          wdata_i = '0;
    logic [3:0]           be_i = '0;
    logic                 gnt_o, rvalid_o, err_o, irq_o;
    logic [31:0]          rdata_o;
    logic [NUM_CH*DW-1:0] reg2ip_data_o;
    logic [NUM_CH-1:0]    reg2ip_en_o;
    logic [NUM_CH-1:0]    reg2ip_ack_i = '0;
    logic [NUM_CH*DW-1:0] ip2reg_data_i = '0;
    logic [NUM_CH-1:0]    ip2reg_valid_i = '0;

    custom_reg_bridge #(.NUM_CH(NUM_CH), .DW(DW), .AW(AW), .ACK_TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .rdata_o(rdata_o), .err_o(err_o), .reg2ip_data_o(reg2ip_data_o),
        .reg2ip_en_o(reg2ip_en_o), .reg2ip_ack_i(reg2ip_ack_i),
        .ip2reg_data_i(ip2reg_data_i), .ip2reg_valid_i(ip2reg_valid_i), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Register-map view: staging/shadow words, sticky flags, and how long each channel has waited.
    logic [31:0] stg [NUM_CH];
    logic [31:0] shd [NUM_CH];
    bit          vld [NUM_CH];
    bit          tmo [NUM_CH];
    int          age [NUM_CH];
    bit          e_rvalid, e_err, e_irq;
    logic [31:0] e_rdata;

    int addr_tbl [11] = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h14, 'h18, 'h1C, 'h20, 'h24, 'h30};

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            stg[i] = '0; shd[i] = '0; vld[i] = 0; tmo[i] = 0; age[i] = -1;
        end
        e_rvalid = 0; e_err = 0; e_irq = 0; e_rdata = '0;
    endtask

    task automatic check_outputs();
        logic [NUM_CH*DW-1:0] e_data;
        logic [NUM_CH-1:0]    e_en;
        for (int i = 0; i < NUM_CH; i++) begin
            e_data[i*DW +: DW] = stg[i];
            e_en[i]            = (age[i] >= 0);
        end
        check("rvalid", rvalid_o, e_rvalid);
        if (e_rvalid) begin
            check("err", err_o, e_err);
            check("rdata", rdata_o, e_rdata);
        end
        check("reg2ip_en", reg2ip_en_o, e_en);
        check("reg2ip_data", reg2ip_data_o, e_data);
        check("irq", irq_o, e_irq);
    endtask

    // Checks gnt_o for the current inputs, then advances the model by one clock.
    task automatic model_step();
        int          w;
        bit          is_w, is_r, is_s, is_c, g, n_err, n_irq, rdclr, cv, ct, ts;
        logic [31:0] st, n_rdata;
        w    = int'(addr_i[AW-1:2]);
        is_w = (w < NUM_CH);
        is_r = (w >= 4) && (w < 4 + NUM_CH);
        is_s = (w == 8);
        is_c = (w == 9);
        g    = req_i && !(we_i && is_w && age[w] >= 0);
        check("gnt", gnt_o, g);

        st = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            st[i] = (age[i] >= 0); st[8+i] = vld[i]; st[16+i] = tmo[i];
        end
        n_err = 0; n_rdata = '0;
        if (g) begin
            if (we_i) n_err = !(is_w || is_c);
            else begin
                n_err = !(is_w || is_r || is_s);
                if (is_w) n_rdata = stg[w];
                else if (is_r) n_rdata = shd[w-4];
                else if (is_s) n_rdata = st;
            end
        end
        n_irq = 0;
        for (int i = 0; i < NUM_CH; i++) n_irq |= tmo[i];

        for (int i = 0; i < NUM_CH; i++) begin
            rdclr = g && !we_i && is_r && (w - 4 == i);
            cv    = g && we_i && is_c && wdata_i[8+i];
            ct    = g && we_i && is_c && wdata_i[16+i];
            ts    = 0;
            if (age[i] >= 0) begin
                if (reg2ip_ack_i[i]) age[i] = -1;
                else if (age[i] == TMO - 1) begin age[i] = -1; ts = 1; end
                else age[i]++;
            end else if (g && we_i && is_w && w == i) begin
                age[i] = 0;
                for (int b = 0; b < 4; b++)
                    if (be_i[b]) stg[i][8*b +: 8] = wdata_i[8*b +: 8];
            end
            if (ip2reg_valid_i[i]) shd[i] = ip2reg_data_i[i*DW +: DW];
            vld[i] = ip2reg_valid_i[i] || (vld[i] && !rdclr && !cv);
            tmo[i] = ts || (tmo[i] && !ct);
        end
        e_rvalid = g; e_err = n_err; e_rdata = n_rdata; e_irq = n_irq;
    endtask

    task automatic drive_random();
        req_i   = ($urandom_range(0, 1) == 1);
        we_i    = ($urandom_range(0, 1) == 1);
        addr_i  = AW'(addr_tbl[$urandom_range(0, 10)] | $urandom_range(0, 3));
        wdata_i = $urandom;
        be_i    = 4'($urandom_range(0, 15));
        for (int i = 0; i < NUM_CH; i++) begin
            reg2ip_ack_i[i]            = ($urandom_range(0, 4) == 0);
            ip2reg_valid_i[i]          = ($urandom_range(0, 5) == 0);
            ip2reg_data_i[i*DW +: DW]  = $urandom;
        end
    endtask

    task automatic drive_idle();
        req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0; be_i = '0;
        reg2ip_ack_i = '0; ip2reg_valid_i = '0; ip2reg_data_i = '0;
    endtask

    initial begin
        model_reset();
        drive_idle();
        repeat (3) @(negedge clk_i);
        check_outputs();
        check("gnt_reset", gnt_o, 1'b0);
        rst_ni = 1'b1;

        for (int c = 0; c < CYCLES; c++) begin
            @(negedge clk_i);
            drive_random();
            #1;
            check_outputs();
            model_step();
        end

        // Asynchronous reset while a handshake is pending.
        @(negedge clk_i);
        drive_idle();
        rst_ni = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk_i);
        rst_ni = 1'b1;
        req_i = 1; we_i = 1; addr_i = 8'h00; wdata_i = 32'hCAFE_0001; be_i = 4'hF;
        #1;
        model_step();
        @(negedge clk_i);
        drive_idle();
        #1;
        check_outputs();
        check("en_before_rst", reg2ip_en_o[0], 1'b1);
        rst_ni = 1'b0;
        #1;
        check("en_async_rst", reg2ip_en_o, '0);
        check("data_async_rst", reg2ip_data_o, '0);
        check("rvalid_async_rst", rvalid_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
